imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader for the pipelined CPU. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them into instruction memory. It holds the CPU in reset until the whole image has been written. It is the write-side counterpart of the end-of-run register/memory readout: it fills the machine state that the bench later dumps.

## Interface
Parameters:
- `BASE_ADDR`, default 32'd0: byte address of the first word written.
- `MAX_WORDS`, default 256: largest word count accepted in the header.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset; one clock, reset is synchronous and active-high.
- `in_valid_i`  in  1  byte on `in_data_i` is valid.
- `in_data_i`  in  8  stream byte.
- `in_ready_o`  out  1  loader accepts a byte this cycle.
- `im_we_o`  out  1  instruction-memory write strobe, one cycle per word.
- `im_addr_o`  out  32  byte address, word aligned.
- `im_wdata_o`  out  32  assembled word.
- `words_o`  out  16  words written so far.
- `cpu_run_o`  out  1  1 = image loaded; drives the CPU's active-low `rst_i`.
- `err_o`  out  1  sticky error flag.

## Operation
- Stream format:
  - Word count N: 2 bytes, low byte first.
  - N words: 4 bytes each, least-significant byte first.
  - Optional checksum byte: see Configuration.
- A byte is accepted on a rising edge where `in_valid_i && in_ready_o`.
- States:
  - HDR0: take the count low byte, go to HDR1.
  - HDR1: take the count high byte. If N == 0, go to DONE (or CSUM). If N > MAX_WORDS, go to ERR. Otherwise go to DATA.
  - DATA: take 4 bytes into the shift register (byte k goes to bits 8k+7:8k). After the 4th byte, go to WRITE.
  - WRITE: `im_we_o`=1 for one cycle. Address = BASE_ADDR + 4*`words_o`; data = the assembled word. `words_o` increments at the end of the cycle. If `words_o`+1 == N, go to DONE (or CSUM); otherwise go back to DATA.
  - CSUM: present only with the macro (see Configuration).
  - DONE: `cpu_run_o`=1. Terminal state.
  - ERR: `err_o`=1, `cpu_run_o`=0. Terminal state.
- `in_ready_o` = 1 only in HDR0, HDR1, DATA and CSUM.
- DONE and ERR are left only by `rst_i`. Bytes offered while in DONE or ERR are never accepted.
- When `in_valid_i` = 0, the FSM holds its state and the partially assembled word; there is no timeout.
- Address arithmetic is 32-bit and unsigned. Because N ≤ MAX_WORDS, the address cannot wrap for legal parameters.

## Timing
- Reset values: state HDR0, `in_ready_o`=1, `im_we_o`=0, `im_addr_o`=0, `im_wdata_o`=0, `words_o`=0, `cpu_run_o`=0, `err_o`=0.
- All outputs are registered, or decoded from state only. There is no combinational path from `in_valid_i` to any output.
- The WRITE cycle directly follows the edge that accepts the 4th byte. `in_ready_o` is 0 during WRITE.
- Best-case throughput is 5 cycles per word.
- `cpu_run_o` rises on the cycle after the final WRITE cycle (or the final CSUM cycle), or on the cycle after HDR1 when N == 0.
- Reset mid-load: the FSM returns to HDR0 and the counters clear on the next edge. Words already written to instruction memory are not erased. `im_we_o` is 0 in the reset cycle.
- When `rst_i` and `in_valid_i` are both high on the same edge, reset wins and the byte is dropped.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined:
  - A running XOR of all data bytes (not the header) is kept.
  - After the last WRITE (or after HDR1 when N == 0), the FSM enters CSUM and accepts one byte.
  - If the byte equals the XOR, go to DONE; otherwise go to ERR.
  - Words are still written before the check, and `words_o` = N in either case.
- Undefined: no CSUM state and no trailing byte. The last WRITE goes straight to DONE, and the XOR logic is absent.

## Test plan
- Stream 02 00, 78 56 34 12, EF BE AD DE with `in_valid_i` held high -> writes (0x0, 0x12345678) then (0x4, 0xDEADBEEF). `words_o`=2. `cpu_run_o`=1 exactly 12 cycles after the first accepted byte.
- Header 00 00 -> no `im_we_o` pulse. `cpu_run_o`=1 on the cycle after HDR1; without the macro, `in_ready_o`=0 from then on.
- Header with N = MAX_WORDS+1 (01 01 for the default 256) -> ERR: `err_o`=1, no writes, `in_ready_o`=0, `cpu_run_o`=0.
- N=1, with `in_valid_i` deasserted for 3 cycles between data bytes 2 and 3 -> the word is assembled correctly and exactly one write occurs.
- Assert `rst_i` after 6 bytes, then send a fresh 1-word image 01 00 AA BB CC DD -> single write (0x0, 0xDDCCBBAA). `words_o`=1, `cpu_run_o`=1.
- With the macro defined, N=1, word bytes 01 02 04 08:
  - Checksum byte 0F -> DONE.
  - Checksum byte 0E -> ERR, with the word still written and `words_o`=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader.
//
// Takes a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and
// writes them into instruction memory. The CPU is held in reset (cpu_run_o = 0) until the whole
// image is written.
//
// Stream: count N (2 bytes, low first), then N words (4 bytes each, LSB first), then one
// checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   Defined:   running XOR of the data bytes is checked against a trailing byte; a mismatch
//              ends in the error state (the words are still written).
//   Undefined: no trailing byte; the last write goes straight to done.
//
// Parameters:
//   BASE_ADDR   byte address of the first word written
//   MAX_WORDS   largest word count accepted in the header
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   stream byte valid
//   in_data_i    stream byte
//   in_ready_o   loader accepts a byte this cycle
//   im_we_o      instruction-memory write strobe, one cycle per word
//   im_addr_o    word-aligned byte address of the write
//   im_wdata_o   assembled word
//   words_o      words written so far
//   cpu_run_o    image loaded; releases the CPU reset
//   err_o        sticky error flag

module imem_loader #(
   parameter logic [31:0] BASE_ADDR = 32'd0,
   parameter int unsigned MAX_WORDS = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        in_valid_i,
   input  logic [7:0]  in_data_i,
   output logic        in_ready_o,
   output logic        im_we_o,
   output logic [31:0] im_addr_o,
   output logic [31:0] im_wdata_o,
   output logic [15:0] words_o,
   output logic        cpu_run_o,
   output logic        err_o
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      StHdr0, StHdr1, StData, StWrite, StCsum, StDone, StErr
   } state_e;
   // State entered once every word has been written.
   localparam state_e StFinal = StCsum;
`else
   typedef enum logic [2:0] {
      StHdr0, StHdr1, StData, StWrite, StDone, StErr
   } state_e;
   localparam state_e StFinal = StDone;
`endif

   state_e      state_q, state_d;
   logic [7:0]  cnt_lo_q;
   logic [15:0] cnt_q;
   logic [1:0]  byte_idx_q;
   logic [31:0] word_q;
   logic [31:0] addr_q;
   logic [15:0] words_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  xor_q;
`endif

   logic        accept;
   logic [15:0] hdr_n;
   logic        last_word;

   always_comb begin
      in_ready_o = 1'b0;
      unique case (state_q)
         StHdr0, StHdr1, StData: in_ready_o = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         StCsum:                 in_ready_o = 1'b1;
`endif
         default:                in_ready_o = 1'b0;
      endcase
   end

   assign accept    = in_valid_i && in_ready_o;
   assign hdr_n     = {in_data_i, cnt_lo_q};
   assign last_word = (words_q + 16'd1) == cnt_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StHdr0: if (accept) state_d = StHdr1;
         StHdr1: begin
            if (accept) begin
               if (hdr_n == 16'd0) begin
                  state_d = StFinal;
               end else if (32'(hdr_n) > MAX_WORDS) begin
                  state_d = StErr;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData:  if (accept && (byte_idx_q == 2'd3)) state_d = StWrite;
         StWrite: state_d = last_word ? StFinal : StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
         StCsum:  if (accept) state_d = (in_data_i == xor_q) ? StDone : StErr;
`endif
         StDone:  state_d = StDone;
         StErr:   state_d = StErr;
         default: state_d = StErr;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StHdr0;
         cnt_lo_q   <= 8'd0;
         cnt_q      <= 16'd0;
         byte_idx_q <= 2'd0;
         word_q     <= 32'd0;
         addr_q     <= 32'd0;
         words_q    <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         xor_q      <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         if (accept && (state_q == StHdr0)) begin
            cnt_lo_q <= in_data_i;
         end
         if (accept && (state_q == StHdr1)) begin
            cnt_q <= hdr_n;
         end
         if (accept && (state_q == StData)) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= in_data_i;
            byte_idx_q                        <= byte_idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q                             <= xor_q ^ in_data_i;
`endif
            // Address is registered here so it is stable for the whole write cycle.
            if (byte_idx_q == 2'd3) begin
               addr_q <= BASE_ADDR + {14'd0, words_q, 2'b00};
            end
         end
         if (state_q == StWrite) begin
            words_q <= words_q + 16'd1;
         end
      end
   end

   // Gated by reset so a write cycle coinciding with a reset never reaches memory.
   assign im_we_o    = (state_q == StWrite) && !rst_i;
   assign im_addr_o  = addr_q;
   assign im_wdata_o = word_q;
   assign words_o    = words_q;
   assign cpu_run_o  = (state_q == StDone);
   assign err_o      = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (default parameters). Also covers the checksum variant when
// IMEM_LOADER_CHECKSUM_EN is defined for both files.
`timescale 1ns/1ps

module tb_imem_loader;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic [7:0]  in_data_i = 8'd0;
   logic        in_ready_o;
   logic        im_we_o;
   logic [31:0] im_addr_o;
   logic [31:0] im_wdata_o;
   logic [15:0] words_o;
   logic        cpu_run_o;
   logic        err_o;

   imem_loader dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .in_valid_i (in_valid_i),
      .in_data_i  (in_data_i),
      .in_ready_o (in_ready_o),
      .im_we_o    (im_we_o),
      .im_addr_o  (im_addr_o),
      .im_wdata_o (im_wdata_o),
      .words_o    (words_o),
      .cpu_run_o  (cpu_run_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   // Write monitor, sampled just after each rising edge.
   logic [31:0] wr_addr [8];
   logic [31:0] wr_data [8];
   int          wr_n = 0;
   always @(posedge clk_i) begin
      #1;
      if (im_we_o) begin
         if (wr_n < 8) begin
            wr_addr[wr_n] = im_addr_o;
            wr_data[wr_n] = im_wdata_o;
         end
         wr_n++;
      end
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // Present a byte and return on the falling edge after it was accepted.
   task automatic send(input logic [7:0] b);
      int t;
      in_valid_i = 1'b1;
      in_data_i  = b;
      t = 0;
      while (!in_ready_o && t < 20) begin
         @(negedge clk_i);
         t++;
      end
      if (!in_ready_o) check("send_ready", {31'd0, in_ready_o}, 32'd1);
      else @(negedge clk_i);
   endtask

   task automatic idle(input int n);
      in_valid_i = 1'b0;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic do_reset();
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      wr_n  = 0;
   endtask

   task automatic wait_end();
      int t;
      in_valid_i = 1'b0;
      t = 0;
      while (!cpu_run_o && !err_o && t < 40) begin
         @(negedge clk_i);
         t++;
      end
   endtask

   int unsigned t_first;
   int unsigned exp_lat;

   initial begin
      @(negedge clk_i);
      do_reset();

      // Reset values.
      check("rst_ready", {31'd0, in_ready_o}, 32'd1);
      check("rst_we",    {31'd0, im_we_o},    32'd0);
      check("rst_addr",  im_addr_o,           32'd0);
      check("rst_wdata", im_wdata_o,          32'd0);
      check("rst_words", {16'd0, words_o},    32'd0);
      check("rst_run",   {31'd0, cpu_run_o},  32'd0);
      check("rst_err",   {31'd0, err_o},      32'd0);

      // Two-word image, valid held high.
      t_first = cyc;
      send(8'h02); send(8'h00);
      send(8'h78); send(8'h56); send(8'h34); send(8'h12);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h2A);
      exp_lat = 13;
`else
      exp_lat = 12;
`endif
      wait_end();
      check("t1_latency", cyc - t_first, exp_lat);
      idle(2);
      check("t1_wr_n",  wr_n,              32'd2);
      check("t1_addr0", wr_addr[0],        32'h0);
      check("t1_data0", wr_data[0],        32'h12345678);
      check("t1_addr1", wr_addr[1],        32'h4);
      check("t1_data1", wr_data[1],        32'hDEADBEEF);
      check("t1_words", {16'd0, words_o},  32'd2);
      check("t1_run",   {31'd0, cpu_run_o}, 32'd1);
      check("t1_ready", {31'd0, in_ready_o}, 32'd0);
      check("t1_err",   {31'd0, err_o},    32'd0);

      // Empty image.
      do_reset();
      send(8'h00); send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("t2_csum_ready", {31'd0, in_ready_o}, 32'd1);
      check("t2_csum_run",   {31'd0, cpu_run_o},  32'd0);
      send(8'h00);
`endif
      check("t2_run",   {31'd0, cpu_run_o},  32'd1);
      check("t2_ready", {31'd0, in_ready_o}, 32'd0);
      idle(3);
      check("t2_wr_n",  wr_n,              32'd0);
      check("t2_words", {16'd0, words_o},  32'd0);

      // Oversized header (MAX_WORDS + 1).
      do_reset();
      send(8'h01); send(8'h01);
      check("t3_err",   {31'd0, err_o},      32'd1);
      check("t3_run",   {31'd0, cpu_run_o},  32'd0);
      check("t3_ready", {31'd0, in_ready_o}, 32'd0);
      in_valid_i = 1'b1;
      in_data_i  = 8'h55;
      repeat (3) @(negedge clk_i);
      check("t3_err_held", {31'd0, err_o}, 32'd1);
      check("t3_wr_n",     wr_n,           32'd0);
      check("t3_words",    {16'd0, words_o}, 32'd0);

      // One word with a 3-cycle gap between data bytes 2 and 3.
      do_reset();
      send(8'h01); send(8'h00);
      send(8'h11); send(8'h22);
      idle(3);
      check("t4_gap_wr_n", wr_n, 32'd0);
      send(8'h33); send(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h44);
`endif
      wait_end();
      idle(2);
      check("t4_wr_n",  wr_n,              32'd1);
      check("t4_addr",  wr_addr[0],        32'h0);
      check("t4_data",  wr_data[0],        32'h44332211);
      check("t4_words", {16'd0, words_o},  32'd1);
      check("t4_run",   {31'd0, cpu_run_o}, 32'd1);

      // Reset mid-load, then a fresh one-word image.
      do_reset();
      send(8'h02); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      idle(2);
      check("t5_pre_words", {16'd0, words_o}, 32'd1);
      do_reset();
      check("t5_rst_words", {16'd0, words_o},    32'd0);
      check("t5_rst_ready", {31'd0, in_ready_o}, 32'd1);
      check("t5_rst_run",   {31'd0, cpu_run_o},  32'd0);
      send(8'h01); send(8'h00);
      send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00);
`endif
      wait_end();
      idle(2);
      check("t5_wr_n",  wr_n,              32'd1);
      check("t5_addr",  wr_addr[0],        32'h0);
      check("t5_data",  wr_data[0],        32'hDDCCBBAA);
      check("t5_words", {16'd0, words_o},  32'd1);
      check("t5_run",   {31'd0, cpu_run_o}, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Checksum good / bad.
      do_reset();
      send(8'h01); send(8'h00);
      send(8'h01); send(8'h02); send(8'h04); send(8'h08);
      send(8'h0F);
      wait_end();
      check("t6_good_run", {31'd0, cpu_run_o}, 32'd1);
      check("t6_good_err", {31'd0, err_o},     32'd0);

      do_reset();
      send(8'h01); send(8'h00);
      send(8'h01); send(8'h02); send(8'h04); send(8'h08);
      send(8'h0E);
      wait_end();
      idle(2);
      check("t6_bad_err",   {31'd0, err_o},     32'd1);
      check("t6_bad_run",   {31'd0, cpu_run_o}, 32'd0);
      check("t6_bad_wr_n",  wr_n,               32'd1);
      check("t6_bad_data",  wr_data[0],         32'h08040201);
      check("t6_bad_words", {16'd0, words_o},   32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
